// File: rtl/vx_csr_req_sched.sv
// Round-robin scheduler sharing one CSR unit between issue slots; holds grant sop..eop.
// Optional drain watchdog enabled by defining VX_CSR_SCHED_WDOG_EN.
module vx_csr_req_sched #(
    parameter int unsigned NUM_REQS    = 4,
    parameter int unsigned WID_W       = 4,
    parameter int unsigned DATAW       = 128,
    parameter int unsigned WDOG_CYCLES = 1024,
    localparam int unsigned SEL_W      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*WID_W-1:0] req_wid,
    input  logic [NUM_REQS-1:0]       req_sop,
    input  logic [NUM_REQS-1:0]       req_eop,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic [WID_W-1:0]          alm_empty_wid,
    input  logic                      alm_empty,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATAW-1:0]          out_data,
    output logic [WID_W-1:0]          out_wid,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      unlock_valid,
    output logic [WID_W-1:0]          unlock_wid,
    output logic                      wdog_err
);

    typedef enum logic [1:0] {StIdle, StDrain, StXfer} state_e;

    state_e           state;
    logic [SEL_W-1:0] grant_r;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W-1:0] next_ptr;
    logic             pick_found;

    logic [WID_W-1:0] wid_a  [NUM_REQS];
    logic [DATAW-1:0] data_a [NUM_REQS];

    if (NUM_REQS < 1 || NUM_REQS > 8 || WDOG_CYCLES == 0 || WDOG_CYCLES > 65535)
    begin : g_param_check
        $error("vx_csr_req_sched: parameter out of range");
    end

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
        assign wid_a[g]  = req_wid[g*WID_W +: WID_W];
        assign data_a[g] = req_data[g*DATAW +: DATAW];
    end

    // First sop-marked requester at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned      idx;
        logic [SEL_W-1:0] idx_s;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        idx_s      = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQS) idx = idx - NUM_REQS;
            idx_s = SEL_W'(idx);
            if (!pick_found && req_valid[idx_s] && req_sop[idx_s]) begin
                pick_found = 1'b1;
                pick_idx   = idx_s;
            end
        end
    end

    assign next_ptr = (grant_r == SEL_W'(NUM_REQS - 1)) ? '0 : grant_r + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state == StXfer) req_ready[grant_r] = out_ready;
        out_valid     = (state == StXfer) && req_valid[grant_r];
        out_data      = data_a[grant_r];
        out_wid       = wid_a[grant_r];
        out_sop       = req_sop[grant_r];
        out_eop       = req_eop[grant_r];
        out_sel       = grant_r;
        alm_empty_wid = wid_a[grant_r];
        unlock_valid  = out_valid && out_ready && out_eop;
        unlock_wid    = wid_a[grant_r];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= StIdle;
            grant_r <= '0;
            rr_ptr  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (pick_found) begin
                        grant_r <= pick_idx;
                        state   <= StDrain;
                    end
                end
                StDrain: begin
                    if (alm_empty) state <= StXfer;
                end
                StXfer: begin
                    if (unlock_valid) begin
                        rr_ptr <= next_ptr;
                        state  <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef VX_CSR_SCHED_WDOG_EN
    logic [15:0] wdog_cnt;
    logic        wdog_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt <= '0;
            wdog_q   <= 1'b0;
        end else if (state == StIdle && pick_found) begin
            wdog_cnt <= '0;
        end else if (state == StDrain) begin
            if (wdog_cnt != 16'hffff) wdog_cnt <= wdog_cnt + 16'd1;
            if ((32'(wdog_cnt) + 32'd1) >= WDOG_CYCLES) wdog_q <= 1'b1;
        end
    end

    assign wdog_err = wdog_q;
`else
    assign wdog_err = 1'b0;
`endif

    // Granted requester must keep valid asserted until its eop is accepted.
    a_grant_valid_held : assert property (
        @(posedge clk) disable iff (reset) (state == StXfer) |-> req_valid[grant_r]
    ) else $error("vx_csr_req_sched: granted requester dropped req_valid mid-op");

endmodule
